coef_loader: RTL and testbench
==============================

# coef_loader

Byte-stream coefficient programmer for the 1D causal convolution filter. Accepts framed coefficient packets on a valid/ready byte stream, validates each frame (length, index range, checksum) into a shadow buffer, then drives the filter's coefficient write port (h_write/h_index/h_value) one tap per cycle. It sits between the host/config path and the filter. A filter's coefficients change only from a fully validated frame.

## Interface
- KERNEL_SIZE, 3, number of filter taps; legal range 1..16
- HEADER, 8'hA5, frame start byte
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  byte valid
- s_data  in  8  frame byte
- s_ready  out  1  loader can accept a byte
- h_write  out  1  coefficient write strobe to filter
- h_index  out  4  tap index being written
- h_value  out  8  coefficient value (signed, two's complement)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: frame committed
- err  out  1  one-cycle pulse: frame rejected

## Operation
- Frame is HEADER, N, IDX, C[0..N-1], CHK.
- A byte transfers on a cycle with s_valid && s_ready.
- States: IDLE, CNT, IDX, DATA, CHK, COMMIT.
- IDLE: a transferred byte equal to HEADER moves to CNT. Any other byte is dropped silently, with no err.
- CNT: N is stored and goes to IDX. If N==0 or N>KERNEL_SIZE: err pulse, back to IDLE.
- IDX: IDX is stored. If IDX+N>KERNEL_SIZE (9-bit compare, no wrap): err, IDLE. Otherwise go to DATA.
- DATA: N bytes are stored in shadow[0..N-1], using a byte counter. After byte N-1 go to CHK.
- CHK: compare the received byte with (N + IDX + ΣC) mod 256, an 8-bit running sum cleared on HEADER.
  - Mismatch: err, IDLE. The filter is untouched.
  - Match: go to COMMIT.
- COMMIT: N consecutive cycles with h_write=1, h_index=IDX+k, h_value=shadow[k], for k=0..N-1. After the last write: done pulse, IDLE.
- A HEADER byte arriving mid-frame is treated as data; there is no resync inside a frame.
- err and done never assert in the same cycle.

## Timing
- Reset values: s_ready=0 while reset is asserted, then 1 in IDLE. h_write=0, h_index=0, h_value=0, busy=0, done=0, err=0. state=IDLE, shadow and sum cleared.
- s_ready is 1 in IDLE, CNT, IDX, DATA and CHK, and 0 in COMMIT. It is a registered state decode, not dependent on s_valid.
- Outputs h_write, h_index, h_value, done and err are registered.
- Validation-error timing: offending byte accepted at cycle T → err=1 at T+1, state=IDLE at T+1, s_ready=1 at T+1.
- Commit timing: CHK byte accepted at T (match) → h_write=1 for cycles T+1..T+N. At T+N+1: done=1, h_write=0, s_ready=1.
- Minimum frame-to-frame gap after CHK is N+1 cycles. s_ready low throttles the source.
- When h_write=0, h_index and h_value hold their last value.
- Reset asserted mid-COMMIT: outputs clear immediately. Taps already written remain written; the filter's own reset handles them.
- Back-to-back frames: HEADER may be offered in the done cycle and is accepted.

## Structure
- Package coef_loader_pkg holds:
  - the state enum (IDLE, CNT, IDX, DATA, CHK, COMMIT),
  - the default HEADER constant,
  - INDEX_W=4 and DATA_W=8 localparams.
- There is a single module with no sub-modules.
- The shadow buffer is a KERNEL_SIZE×8 register array inside coef_loader.
- The checksum is an 8-bit accumulator inside coef_loader.

## Test plan
- **Good frame:** after reset, send A5,03,00,05,FA,02,02 (sum 03+00+05+FA+02=0x04? no: 0x104 mod 256 = 0x04; send CHK=04). Required response:
  - h_write high 3 cycles with (0,05), (1,FA), (2,02);
  - done pulse at CHK+4;
  - no err.
- **Checksum mismatch:** send A5,02,01,10,20 with CHK=00 (correct is 0x33). Required response: err at CHK+1, h_write never asserts, busy low at CHK+1.
- **Range errors:**
  - send A5,00 → err the cycle after the count byte;
  - send A5,02,02 with KERNEL_SIZE=3 → err the cycle after the IDX byte.
- **Garbage and backpressure:**
  - send 11,22,A5,01,02,7F,82 with random s_valid gaps → single write (2,7F), done, no err from the leading garbage;
  - hold s_valid=1 during COMMIT → s_ready=0, no bytes lost.
- **Reset mid-commit:** assert reset during the second COMMIT cycle of a 3-tap frame → h_write=0 immediately, state IDLE after release, the next good frame commits normally.

Source files
------------

// File: rtl/coef_loader_pkg.sv
// coef_loader_pkg: shared types and constants for the coefficient loader.
//   state_e        - frame parser / commit sequencer states
//   DEFAULT_HEADER - frame start byte
//   INDEX_W        - width of the filter tap index
//   DATA_W         - width of a stream byte / coefficient
package coef_loader_pkg;

  localparam int INDEX_W = 4;
  localparam int DATA_W  = 8;

  localparam logic [DATA_W-1:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT,
    IDX,
    DATA,
    CHK,
    COMMIT
  } state_e;

endpackage

// File: rtl/coef_loader.sv
// coef_loader: receives framed coefficient packets on a valid/ready byte
// stream (HEADER, N, IDX, C[0..N-1], CHK), validates count, index range and
// checksum into a shadow buffer, then writes the taps into the filter one
// per cycle. The filter only ever sees coefficients from a validated frame.
//
// Ports:
//   clk      - rising-edge clock
//   reset    - asynchronous active-low reset
//   s_valid  - input byte valid
//   s_data   - input frame byte
//   s_ready  - loader accepts a byte (low during commit and in reset)
//   h_write  - coefficient write strobe to the filter
//   h_index  - tap index being written
//   h_value  - signed coefficient value
//   busy     - high whenever a frame is in progress
//   done     - one-cycle pulse: frame committed
//   err      - one-cycle pulse: frame rejected
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter int                KERNEL_SIZE = 3,
  parameter logic [DATA_W-1:0] HEADER      = DEFAULT_HEADER
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_valid,
  input  logic [DATA_W-1:0]         s_data,
  output logic                      s_ready,
  output logic                      h_write,
  output logic [INDEX_W-1:0]        h_index,
  output logic signed [DATA_W-1:0]  h_value,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int         SH_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [8:0] KS9  = 9'(KERNEL_SIZE);

  state_e                   state_q, state_d;
  logic [4:0]               n_q, n_d;       // tap count, 1..16 once validated
  logic [INDEX_W-1:0]       idx_q, idx_d;
  logic [4:0]               cnt_q, cnt_d;   // data byte / commit tap counter
  logic [DATA_W-1:0]        sum_q, sum_d;
  logic signed [DATA_W-1:0] shadow_q [KERNEL_SIZE];
  logic signed [DATA_W-1:0] shadow_d [KERNEL_SIZE];
  logic                     s_ready_q, s_ready_d;
  logic                     h_write_q, h_write_d;
  logic [INDEX_W-1:0]       h_index_q, h_index_d;
  logic signed [DATA_W-1:0] h_value_q, h_value_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic xfer;
  assign xfer = s_valid && s_ready_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    shadow_d  = shadow_q;
    h_write_d = 1'b0;
    h_index_d = h_index_q;
    h_value_d = h_value_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Non-header bytes are discarded without complaint.
        if (xfer && s_data == HEADER) begin
          sum_d   = '0;
          state_d = CNT;
        end
      end
      CNT: begin
        if (xfer) begin
          n_d   = s_data[4:0];
          sum_d = sum_q + s_data;
          if (s_data == '0 || {1'b0, s_data} > KS9) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = IDX;
          end
        end
      end
      IDX: begin
        if (xfer) begin
          idx_d = s_data[INDEX_W-1:0];
          sum_d = sum_q + s_data;
          cnt_d = '0;
          // 9-bit sum so a large IDX cannot wrap into the legal range.
          if ({1'b0, s_data} + {4'b0, n_q} > KS9) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // A HEADER value here is ordinary coefficient data.
        if (xfer) begin
          shadow_d[cnt_q[SH_W-1:0]] = s_data;
          sum_d = sum_q + s_data;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q + 5'd1 == n_q) state_d = CHK;
        end
      end
      CHK: begin
        if (xfer) begin
          if (s_data != sum_q) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            // Tap 0 goes out on the cycle right after the checksum byte.
            h_write_d = 1'b1;
            h_index_d = idx_q;
            h_value_d = shadow_q[0];
            cnt_d     = 5'd1;
            state_d   = COMMIT;
          end
        end
      end
      COMMIT: begin
        if (cnt_q == n_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          h_write_d = 1'b1;
          h_index_d = idx_q + cnt_q[INDEX_W-1:0];
          h_value_d = shadow_q[cnt_q[SH_W-1:0]];
          cnt_d     = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is a registered decode of the upcoming state.
  assign s_ready_d = (state_d != COMMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      shadow_q  <= '{default: '0};
      s_ready_q <= 1'b0;
      h_write_q <= 1'b0;
      h_index_q <= '0;
      h_value_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      shadow_q  <= shadow_d;
      s_ready_q <= s_ready_d;
      h_write_q <= h_write_d;
      h_index_q <= h_index_d;
      h_value_q <= h_value_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign s_ready = s_ready_q;
  assign h_write = h_write_q;
  assign h_index = h_index_q;
  assign h_value = h_value_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_coef_loader.sv
// tb_coef_loader: scoreboard bench for coef_loader. A driver sends byte
// streams; a frame-level reference model predicts the write/done/err events
// and their cycles, and a monitor process compares them as the DUT emits.
module tb_coef_loader;

  localparam int         K   = 3;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] idx;
    logic [7:0] val;
  } ev_t;
  typedef ev_t ev_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        h_write;
  logic [3:0]  h_index;
  logic signed [7:0] h_value;
  logic        busy, done, err;

  int    ncnt = 0;
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;
  ev_q_t exp_q;

  coef_loader #(.KERNEL_SIZE(K), .HEADER(HDR)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .h_write(h_write), .h_index(h_index),
    .h_value(h_value), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncnt <= ncnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, ncnt);
    end
  endtask

  task automatic finish_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic ev_t mk(input int cyc, input int kind, input logic [3:0] idx, input logic [7:0] val);
    ev_t e;
    e.cyc = cyc; e.kind = kind; e.idx = idx; e.val = val;
    return e;
  endfunction

  // Frame-level reference: outcome of one frame from its fields. Event
  // cycles are relative to the transfer of the deciding byte (index dec).
  function automatic void model(input byte_q_t b, output int dec, output ev_q_t ev);
    int p, n, idx, sum;
    ev = {};
    p = 0;
    while (p < b.size() && b[p] != HDR) p++;
    n = int'(b[p+1]);
    if (n == 0 || n > K) begin
      dec = p + 1;
      ev.push_back(mk(1, EV_ERR, 4'h0, 8'h00));
      return;
    end
    idx = int'(b[p+2]);
    if (idx + n > K) begin
      dec = p + 2;
      ev.push_back(mk(1, EV_ERR, 4'h0, 8'h00));
      return;
    end
    sum = n + idx;
    for (int k = 0; k < n; k++) sum += int'(b[p+3+k]);
    dec = p + 3 + n;
    if (int'(b[dec]) != sum % 256) begin
      ev.push_back(mk(1, EV_ERR, 4'h0, 8'h00));
    end else begin
      for (int k = 0; k < n; k++) ev.push_back(mk(1 + k, EV_WR, 4'(idx + k), b[p+3+k]));
      ev.push_back(mk(n + 1, EV_DONE, 4'h0, 8'h00));
    end
  endfunction

  // Called at a negedge; returns at the negedge after the last transfer.
  // s_valid is left high so a following stream can continue back-to-back.
  task automatic send_stream(input byte_q_t b, input int gap_max, input int max_ev);
    int    dec, g, w, t;
    ev_q_t ev;
    model(b, dec, ev);
    for (int i = 0; i < b.size(); i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (g > 0) begin
        s_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = b[i];
      w = 0;
      while (!s_ready) begin
        @(negedge clk);
        w++;
        if (w > 200) begin
          total++; bad++;
          $display("FAIL ready_timeout: s_ready stayed 0 for %0d cycles, expected 1", w);
          finish_test();
        end
      end
      t = ncnt;
      if (i == dec) begin
        for (int j = 0; j < ev.size() && j < max_ev; j++) begin
          ev[j].cyc = ev[j].cyc + t;
          exp_q.push_back(ev[j]);
        end
      end
      @(negedge clk);
    end
  endtask

  function automatic byte_q_t rand_frame();
    byte_q_t    b;
    int         r, n, idx, sum, ng;
    logic [7:0] g, c;
    b  = {};
    ng = int'($urandom_range(2, 0));
    for (int i = 0; i < ng; i++) begin
      g = 8'($urandom_range(255, 0));
      if (g == HDR) g = 8'h00;
      b.push_back(g);
    end
    b.push_back(HDR);
    r = int'($urandom_range(9, 0));
    if (r == 0) begin
      n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, K + 1));
      b.push_back(8'(n));
    end else if (r == 1) begin
      n   = int'($urandom_range(K, 1));
      idx = int'($urandom_range(255, K - n + 1));
      b.push_back(8'(n));
      b.push_back(8'(idx));
    end else begin
      n   = int'($urandom_range(K, 1));
      idx = int'($urandom_range(K - n, 0));
      b.push_back(8'(n));
      b.push_back(8'(idx));
      sum = n + idx;
      for (int k = 0; k < n; k++) begin
        c = 8'($urandom_range(255, 0));
        b.push_back(c);
        sum += int'(c);
      end
      c = 8'(sum);
      if (r <= 3) c = c ^ 8'($urandom_range(255, 1));
      b.push_back(c);
    end
    return b;
  endfunction

  // Monitor: every emitted event must be the next expected one, on its cycle.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == ncnt) begin
        e = exp_q.pop_front();
        if (e.kind == EV_WR)
          check("write", {14'h0, h_write, done, err, s_ready, busy, h_index, h_value},
                {14'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e.idx, e.val});
        else if (e.kind == EV_DONE)
          check("done", {27'h0, h_write, done, err, s_ready, busy},
                {27'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        else
          check("err", {27'h0, h_write, done, err, s_ready, busy},
                {27'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      end else if (h_write || done || err) begin
        total++; bad++;
        $display("FAIL unexpected_event: h_write=%b done=%b err=%b expected none (cycle %0d)",
                 h_write, done, err, ncnt);
      end
    end
  end

  initial begin
    byte_q_t b;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'h0);
    check("rst_outputs", {24'h0, h_write, busy, done, err, h_index},
          {24'h0, 4'h0, 4'h0});
    check("rst_h_value", 32'(h_value), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 32'(s_ready), 32'h1);
    check("idle_busy", 32'(busy), 32'h0);
    mon_en = 1'b1;

    // Good frame
    b = '{8'hA5, 8'h03, 8'h00, 8'h05, 8'hFA, 8'h02, 8'h04};
    send_stream(b, 0, 1000);
    // Checksum mismatch
    b = '{8'hA5, 8'h02, 8'h01, 8'h10, 8'h20, 8'h00};
    send_stream(b, 0, 1000);
    // Count and index range errors
    b = '{8'hA5, 8'h00};
    send_stream(b, 0, 1000);
    b = '{8'hA5, 8'h02, 8'h02};
    send_stream(b, 0, 1000);
    // Leading garbage with random valid gaps
    b = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'h02, 8'h7F, 8'h82};
    send_stream(b, 3, 1000);
    // Back-to-back frames, s_valid held high through commit
    b = '{8'hA5, 8'h02, 8'h01, 8'hA5, 8'h80, 8'h28};
    send_stream(b, 0, 1000);
    b = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h00};
    send_stream(b, 0, 1000);
    s_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Reset in the second commit cycle of a 3-tap frame
    b = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h69};
    send_stream(b, 0, 1);
    s_valid = 1'b0;
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("midrst_outputs", {20'h0, h_write, busy, done, err, s_ready, 3'h0, h_index},
          {20'h0, 5'h0, 3'h0, 4'h0});
    check("midrst_h_value", 32'(h_value), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("postrst_ready", {30'h0, s_ready, busy}, {30'h0, 1'b1, 1'b0});
    check("postrst_queue", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    mon_en = 1'b1;
    b = '{8'hA5, 8'h02, 8'h01, 8'h9C, 8'h64, 8'h03};
    send_stream(b, 1, 1000);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      b = rand_frame();
      send_stream(b, int'($urandom_range(3, 0)), 1000);
    end

    s_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("drain_queue", 32'(exp_q.size()), 32'h0);
    finish_test();
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached, expected completion");
    bad++;
    finish_test();
  end

endmodule
